mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive data grants that may pass a waiting fetch.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low (0 = in reset).
REQ-006 if_req  input  1  instruction-fetch read request.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid.
REQ-010 if_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  load/store request.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_W  load/store address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  load/store request accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid.
REQ-017 d_rdata  output  DATA_W  load data.
REQ-018 mem_addr  output  ADDR_W  address to single-port memory.
REQ-019 mem_ren  output  1  memory read strobe.
REQ-020 mem_wen  output  1  memory write strobe.
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_ren.

Function
REQ-023 Grants SHALL be combinational from the same-cycle requests; if_gnt and d_gnt SHALL never both be 1.
REQ-024 A requester SHALL hold req/addr/we/wdata stable until its gnt; the gnt cycle is the transfer cycle.
REQ-025 Only one requester active -> that requester SHALL be granted.
REQ-026 Both active -> data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-027 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each cycle d_gnt=1 with if_req=1, and clear on if_gnt=1 or if_req=0.
REQ-028 mem_addr/mem_wdata SHALL carry the granted requester's address/data; with no grant, mem_addr=0, mem_wdata=0, mem_ren=0, mem_wen=0.
REQ-029 mem_ren = if_gnt | (d_gnt & ~d_we); mem_wen = d_gnt & d_we.
REQ-030 A response-owner FSM SHALL have states IDLE, RD_IF, RD_D; next state RD_IF on if_gnt, RD_D on load grant, else IDLE (stores -> IDLE).
REQ-031 In RD_IF: if_rvalid=1, if_rdata=mem_rdata; in RD_D: d_rvalid=1, d_rdata=mem_rdata; otherwise rvalid=0 and rdata=0.
REQ-032 Read latency SHALL be exactly 1 cycle from grant to rvalid; stores produce no rvalid.
REQ-033 Back-to-back grants every cycle SHALL be supported; a response SHALL overlap the next grant without stall.
REQ-034 Responses SHALL return in grant order; store at N then load of same address at N+1 returns stored value (memory ordering preserved).

Reset
REQ-035 While rst=0: FSM=IDLE, starve_cnt=0, all rvalid=0, all rdata=0; grants and mem strobes SHALL be 0 regardless of requests.
REQ-036 Reset asserted with a read outstanding SHALL discard it; no rvalid SHALL appear in the first cycle after rst rises.

Structure
REQ-037 The FSM state enum and default widths (ADDR_W, DATA_W) SHALL live in the shared core package.
REQ-038 The block SHALL be one module; the starvation counter MAY be a sub-module named starve_ctr.

Verification
REQ-039 Fetch only: if_req=1, if_addr=0x0010, mem_rdata=0xA5A5 next cycle -> if_gnt same cycle, if_rvalid=1, if_rdata=0xA5A5 one cycle later.
REQ-040 Store then load: d_we=1, d_addr=0x0020, d_wdata=0x1234 at N; load 0x0020 at N+1 -> mem_wen at N, d_rvalid=1, d_rdata=0x1234 at N+2, no rvalid at N+1.
REQ-041 Contention: if_req and d_req (loads) held 1 continuously -> d_gnt 4 cycles, if_gnt 5th cycle, pattern repeats; responses routed to correct owner.
REQ-042 Idle: no requests -> mem_addr=0, mem_ren=0, mem_wen=0, both rvalid=0.
REQ-043 Reset mid-read: if_gnt at N, rst=0 during N+1 -> if_rvalid=0 throughout and after release, FSM IDLE, starve_cnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester single-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_IF = 2'd1,
    ST_RD_D  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch port, load/store port and single-port memory bus as seen by the arbiter.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master: requesters plus memory; slave: the arbiter
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_ren, mem_wen, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_ren, mem_wen, mem_wdata
  );

endinterface

// File: rtl/starve_ctr.sv
// Counts data grants that pass a waiting fetch; full forces the next contended grant to fetch.
module starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic full
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  assign full = (cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (if_gnt || !if_req) begin
      cnt <= '0;
    end else if (d_gnt && !full) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and load/store onto one single-port memory; routes read data back by owner.
//   state    | meaning
//   ST_IDLE  | no read in flight, rvalid low
//   ST_RD_IF | fetch read granted last cycle, mem_rdata goes to fetch port
//   ST_RD_D  | load granted last cycle, mem_rdata goes to data port
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arb_if.slave    bus
);

  logic   starve_full;
  logic   win_if;
  logic   win_d;
  owner_e state;
  logic   if_rvalid_q;
  logic   d_rvalid_q;

  // grants are forced low while reset is asserted
  assign win_if = rst & bus.if_req & (~bus.d_req | starve_full);
  assign win_d  = rst & bus.d_req & ~win_if;

  assign bus.if_gnt    = win_if;
  assign bus.d_gnt     = win_d;
  assign bus.mem_addr  = win_if ? bus.if_addr : (win_d ? bus.d_addr : {ADDR_W{1'b0}});
  assign bus.mem_wdata = win_d ? bus.d_wdata : {DATA_W{1'b0}};
  assign bus.mem_ren   = win_if | (win_d & ~bus.d_we);
  assign bus.mem_wen   = win_d & bus.d_we;

  starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .if_gnt (win_if),
    .d_gnt  (win_d),
    .full   (starve_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else if (win_if) begin
      state       <= ST_RD_IF;
      if_rvalid_q <= 1'b1;
      d_rvalid_q  <= 1'b0;
    end else if (win_d && !bus.d_we) begin
      state       <= ST_RD_D;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b1;
    end else begin
      state       <= ST_IDLE;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end
  end

  // memory returns data the cycle after the strobe, so rdata is steered straight through
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = (state == ST_RD_IF) ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata   = (state == ST_RD_D)  ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: reference arbiter/memory model predicts grants and responses.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    logic [1:0]  owner;  // 0 none, 1 fetch, 2 data
    logic [15:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if bus ();

  mem_arb #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] phys [0:255];
  logic [15:0] mdl  [0:255];
  rsp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          sc_m  = 0;

  // memory behind the arbiter, driven only by DUT strobes
  always @(posedge clk) begin
    if (bus.mem_wen) phys[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= phys[bus.mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_rsp();
    rsp_t r;
    r.owner = 2'd0;
    r.data  = 16'h0;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, r.owner == 2'd1});
    chk("if_rdata",  {16'b0, bus.if_rdata},  (r.owner == 2'd1) ? {16'b0, r.data} : 32'h0);
    chk("d_rvalid",  {31'b0, bus.d_rvalid},  {31'b0, r.owner == 2'd2});
    chk("d_rdata",   {16'b0, bus.d_rdata},   (r.owner == 2'd2) ? {16'b0, r.data} : 32'h0);
  endtask

  task automatic step(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                      input logic [15:0] da, input logic [15:0] dw,
                      output logic eig, output logic edg);
    rsp_t r;
    @(negedge clk);
    check_rsp();
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dw;
    #1;
    eig = ir && (!dr || sc_m == LIMIT);
    edg = dr && !eig;
    chk("if_gnt",    {31'b0, bus.if_gnt},  {31'b0, eig});
    chk("d_gnt",     {31'b0, bus.d_gnt},   {31'b0, edg});
    chk("mem_addr",  {16'b0, bus.mem_addr}, eig ? {16'b0, ia} : (edg ? {16'b0, da} : 32'h0));
    chk("mem_wdata", {16'b0, bus.mem_wdata}, edg ? {16'b0, dw} : 32'h0);
    chk("mem_ren",   {31'b0, bus.mem_ren}, {31'b0, eig || (edg && !dwe)});
    chk("mem_wen",   {31'b0, bus.mem_wen}, {31'b0, edg && dwe});
    r.owner = 2'd0;
    r.data  = 16'h0;
    if (eig) begin
      r.owner = 2'd1;
      r.data  = mdl[ia[7:0]];
    end else if (edg && !dwe) begin
      r.owner = 2'd2;
      r.data  = mdl[da[7:0]];
    end
    exp_q.push_back(r);
    if (edg && dwe) mdl[da[7:0]] = dw;
    if (eig || !ir) sc_m = 0;
    else if (edg && sc_m < LIMIT) sc_m++;
  endtask

  task automatic idle_step();
    logic g1, g2;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, g1, g2);
  endtask

  task automatic check_in_reset();
    chk("rst_if_gnt",    {31'b0, bus.if_gnt},    32'h0);
    chk("rst_d_gnt",     {31'b0, bus.d_gnt},     32'h0);
    chk("rst_mem_ren",   {31'b0, bus.mem_ren},   32'h0);
    chk("rst_mem_wen",   {31'b0, bus.mem_wen},   32'h0);
    chk("rst_mem_addr",  {16'b0, bus.mem_addr},  32'h0);
    chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    chk("rst_d_rvalid",  {31'b0, bus.d_rvalid},  32'h0);
    chk("rst_if_rdata",  {16'b0, bus.if_rdata},  32'h0);
    chk("rst_d_rdata",   {16'b0, bus.d_rdata},   32'h0);
  endtask

  // reset pulse lasting one cycle with both requests asserted
  task automatic reset_cycle();
    rsp_t r;
    @(negedge clk);
    rst         = 1'b0;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    #1;
    check_in_reset();
    exp_q.delete();
    sc_m    = 0;
    r.owner = 2'd0;
    r.data  = 16'h0;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    rst        = 1'b1;
  endtask

  initial begin
    logic        g_if, g_d;
    logic        ir, dr, dwe;
    logic [15:0] ia, da, dw;

    for (int i = 0; i < 256; i++) begin
      phys[i] = 16'(i * 257) ^ 16'h5A00;
      mdl[i]  = 16'(i * 257) ^ 16'h5A00;
    end
    phys[8'h10] = 16'hA5A5;
    mdl[8'h10]  = 16'hA5A5;

    rst         = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0020;
    bus.d_wdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    #1;
    check_in_reset();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // fetch only: A5A5 returned one cycle after grant
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, g_if, g_d);
    idle_step();

    // store then load of the same address back to back
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1234, g_if, g_d);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, g_if, g_d);
    idle_step();
    chk("ref_store_0020", {16'b0, mdl[8'h20]}, 32'h1234);

    // sustained contention: four data grants then one fetch, repeating
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 16'h0030 + 16'(i), 1'b1, 1'b0, 16'h0040 + 16'(i), 16'h0, g_if, g_d);
      chk("contend_pattern", {31'b0, g_if}, {31'b0, (i % 5) == 4});
    end
    idle_step();
    idle_step();

    // random traffic; a request is held until granted
    ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = 16'h0; da = 16'h0; dw = 16'h0;
    g_if = 1'b1; g_d = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (g_if || !ir) begin
        ir = 1'($urandom_range(0, 1));
        ia = 16'(16'h0020 + $urandom_range(0, 15));
      end
      if (g_d || !dr) begin
        dr  = 1'($urandom_range(0, 1));
        dwe = 1'($urandom_range(0, 1));
        da  = 16'(16'h0020 + $urandom_range(0, 15));
        dw  = 16'($urandom_range(0, 65535));
      end
      step(ir, ia, dr, dwe, da, dw, g_if, g_d);
    end
    idle_step();

    // reset arriving while a fetch read is outstanding
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, g_if, g_d);
    reset_cycle();
    idle_step();
    step(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0012, 16'h0, g_if, g_d);
    chk("post_rst_starve", {30'b0, g_if, g_d}, 32'h1);
    idle_step();
    idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
